sweep_controller: RTL and testbench

SWEEP_CONTROLLER -- requirements
Module: sweep_controller

---
 rtl/sweep_pkg.sv | 41 ++++
 rtl/sweep_watchdog.sv | 41 ++++
 rtl/sweep_controller.sv | 150 +++++++++++++++
 tb/tb_sweep_controller.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// Shared types and defaults for the up/down sweep controller.
// Imported by the controller and its watchdog.
package sweep_pkg;

    localparam int WIDTH_DEF = 5;
    localparam int CYC_W_DEF = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RISE   = 3'd2,
        FALL   = 3'd3,
        FINISH = 3'd4
    } state_e;

    typedef struct packed {
        logic load;
        logic up;
        logic down;
        logic busy;
        logic done;
    } drive_t;

    function automatic logic is_sweep(input state_e s);
        return (s == RISE) || (s == FALL);
    endfunction

    function automatic drive_t drive_of(input state_e s);
        drive_t d;
        d = '0;
        unique case (s)
            LOAD:    begin d.load = 1'b1; d.busy = 1'b1; end
            RISE:    begin d.up   = 1'b1; d.busy = 1'b1; end
            FALL:    begin d.down = 1'b1; d.busy = 1'b1; end
            FINISH:  begin d.done = 1'b1; d.busy = 1'b1; end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/sweep_watchdog.sv
// Cycle counter bounding how long one RISE or FALL phase may wait for its flag.
// timeout_o fires during the last permitted cycle of a phase.
module sweep_watchdog
    import sweep_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic timeout_o
);

    localparam int CW = WIDTH + 2;
    // A full sweep needs 2^WIDTH steps; two spare cycles cover flag latency.
    localparam logic [CW-1:0] LAST = CW'((1 << WIDTH) + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign timeout_o = enable_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !timeout_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sweep_controller.sv
// Drives an external saturating up/down counter through repeated full sweeps.
// All outputs are registered and decoded from the next state.
module sweep_controller
    import sweep_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CYC_W = CYC_W_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic             Stop,
    input  logic [WIDTH-1:0] Seed,
    input  logic [CYC_W-1:0] Cycles,
    input  logic [WIDTH-1:0] Counter,
    input  logic             High,
    input  logic             Low,
    output logic [WIDTH-1:0] IN,
    output logic             Load,
    output logic             Up,
    output logic             Down,
    output logic             Busy,
    output logic             Done,
    output logic             Err,
    output logic [CYC_W-1:0] Sweep_Cnt
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [CYC_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] in_q, in_d;
    drive_t           drv_q, drv_d;

    logic wd_clear;
    logic wd_enable;
    logic wd_timeout;

    // Control decisions use only the flags; the raw value is not needed.
    logic unused_counter;
    assign unused_counter = ^Counter;

    assign wd_enable = is_sweep(state_q);
    assign wd_clear  = (state_d == LOAD)
                    || (is_sweep(state_q) && (state_d != state_q));

    sweep_watchdog #(
        .WIDTH (WIDTH)
    ) u_watchdog (
        .clk_i     (CLK),
        .rst_i     (RST),
        .clear_i   (wd_clear),
        .enable_i  (wd_enable),
        .timeout_o (wd_timeout)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            seed_q  <= '0;
            cyc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            in_q    <= '0;
            drv_q   <= '0;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            cyc_q   <= cyc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            in_q    <= in_d;
            drv_q   <= drv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        cyc_d   = cyc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    seed_d  = Seed;
                    cyc_d   = Cycles;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = Stop ? FINISH : RISE;
            end
            RISE: begin
                if (Stop) begin
                    state_d = FINISH;
                end else if (High) begin
                    state_d = FALL;
                end else if (wd_timeout) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end
            end
            FALL: begin
                if (Stop) begin
                    state_d = FINISH;
                end else if (Low) begin
                    cnt_d = cnt_q + 1'b1;
                    // Cycles of zero never matches, so the count wraps freely.
                    if ((cyc_q != '0) && (cnt_d == cyc_q)) begin
                        state_d = FINISH;
                    end else begin
                        state_d = RISE;
                    end
                end else if (wd_timeout) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        drv_d = drive_of(state_d);
        in_d  = '0;
        if (state_d == LOAD) begin
            in_d = seed_d;
        end
    end

    assign IN        = in_q;
    assign Load      = drv_q.load;
    assign Up        = drv_q.up;
    assign Down      = drv_q.down;
    assign Busy      = drv_q.busy;
    assign Done      = drv_q.done;
    assign Err       = err_q;
    assign Sweep_Cnt = cnt_q;

endmodule

// File: tb/tb_sweep_controller.sv
// Directed bench for sweep_controller with an attached saturating counter
// and a phase-level reference model compared on every falling edge.
module tb_sweep_controller;

    localparam int W     = 5;
    localparam int CW    = 4;
    localparam int MAXV  = (1 << W) - 1;
    localparam int WDLIM = (1 << W) + 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          Start = 1'b0;
    logic          Stop = 1'b0;
    logic [W-1:0]  Seed = '0;
    logic [CW-1:0] Cycles = '0;
    logic [W-1:0]  Counter;
    logic          High;
    logic          Low;
    logic [W-1:0]  IN;
    logic          Load, Up, Down, Busy, Done, Err;
    logic [CW-1:0] Sweep_Cnt;

    int tests = 0;
    int fails = 0;

    logic kill_high = 1'b0;
    int   ctr = 0;

    sweep_controller #(
        .WIDTH (W),
        .CYC_W (CW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Start     (Start),
        .Stop      (Stop),
        .Seed      (Seed),
        .Cycles    (Cycles),
        .Counter   (Counter),
        .High      (High),
        .Low       (Low),
        .IN        (IN),
        .Load      (Load),
        .Up        (Up),
        .Down      (Down),
        .Busy      (Busy),
        .Done      (Done),
        .Err       (Err),
        .Sweep_Cnt (Sweep_Cnt)
    );

    always #5 CLK = ~CLK;

    // External saturating counter driven by the controller
    always @(posedge CLK) begin
        if (Load === 1'b1)                  ctr <= int'(IN);
        else if (Up === 1'b1 && ctr < MAXV) ctr <= ctr + 1;
        else if (Down === 1'b1 && ctr > 0)  ctr <= ctr - 1;
    end

    assign Counter = W'(ctr);
    assign High    = !kill_high && (ctr == MAXV);
    assign Low     = (ctr == 0);

    // Reference model: phase, latched run parameters, sweeps and phase age
    typedef enum {P_IDLE, P_LOAD, P_RISE, P_FALL, P_FIN} phase_t;
    phase_t m_ph = P_IDLE;
    int     m_seed = 0;
    int     m_cyc = 0;
    int     m_sweeps = 0;
    int     m_err = 0;
    int     m_age = 0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_ph <= P_IDLE;
            m_sweeps <= 0;
            m_err <= 0;
            m_age <= 0;
        end else begin
            case (m_ph)
                P_IDLE: if (Start) begin
                    m_seed <= int'(Seed);
                    m_cyc <= int'(Cycles);
                    m_sweeps <= 0;
                    m_err <= 0;
                    m_age <= 0;
                    m_ph <= P_LOAD;
                end
                P_LOAD: m_ph <= Stop ? P_FIN : P_RISE;
                P_RISE: begin
                    if (Stop) m_ph <= P_FIN;
                    else if (High) begin m_ph <= P_FALL; m_age <= 0; end
                    else if (m_age + 1 == WDLIM) begin m_ph <= P_FIN; m_err <= 1; end
                    else m_age <= m_age + 1;
                end
                P_FALL: begin
                    if (Stop) m_ph <= P_FIN;
                    else if (Low) begin
                        m_sweeps <= (m_sweeps + 1) % (1 << CW);
                        m_age <= 0;
                        if (m_cyc != 0 && (m_sweeps + 1) % (1 << CW) == m_cyc) m_ph <= P_FIN;
                        else m_ph <= P_RISE;
                    end
                    else if (m_age + 1 == WDLIM) begin m_ph <= P_FIN; m_err <= 1; end
                    else m_age <= m_age + 1;
                end
                default: m_ph <= P_IDLE;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("m_in", 32'(IN), (m_ph == P_LOAD) ? 32'(m_seed) : 32'd0);
        chk("m_load", 32'(Load), 32'(m_ph == P_LOAD));
        chk("m_up", 32'(Up), 32'(m_ph == P_RISE));
        chk("m_down", 32'(Down), 32'(m_ph == P_FALL));
        chk("m_busy", 32'(Busy), 32'(m_ph != P_IDLE));
        chk("m_done", 32'(Done), 32'(m_ph == P_FIN));
        chk("m_err", 32'(Err), 32'(m_err));
        chk("m_sweep", 32'(Sweep_Cnt), 32'(m_sweeps));
        tests++;
        if (32'(Load) + 32'(Up) + 32'(Down) > 1) begin
            fails++;
            $display("FAIL onehot: Load=%b Up=%b Down=%b, required at most one", Load, Up, Down);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        compare_model();
    endtask

    task automatic start_run(input int s, input int c);
        tick();
        Seed = W'(s);
        Cycles = CW'(c);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("load_pulse", 32'(Load), 32'd1);
        chk("load_in", 32'(IN), 32'(s));
    endtask

    task automatic wait_idle(input int budget, output int ups, output int dns,
                             output int dones, output int err_done);
        ups = 0; dns = 0; dones = 0; err_done = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (Up === 1'b1) ups++;
            if (Down === 1'b1) dns++;
            if (Done === 1'b1) begin dones++; err_done = int'(Err); end
            if (Busy === 1'b0) break;
        end
        chk("run_ended", 32'(Busy), 32'd0);
    endtask

    int ups, dns, dones, errd;
    int prev;
    logic wrapped;

    initial begin
        repeat (2) @(posedge CLK);
        tick();
        chk("rst_in", 32'(IN), 0);
        chk("rst_drive", {29'd0, Load, Up, Down}, 0);
        chk("rst_status", {29'd0, Busy, Done, Err}, 0);
        chk("rst_sweep", 32'(Sweep_Cnt), 0);
        RST = 1'b0;
        tick();

        // Seed 3, one sweep: 29 Up cycles to reach and sample 31, 32 Down to 0
        start_run(3, 1);
        wait_idle(200, ups, dns, dones, errd);
        chk("s3_ups", ups, 29);
        chk("s3_dns", dns, 32);
        chk("s3_done", dones, 1);
        chk("s3_sweep", 32'(Sweep_Cnt), 1);
        chk("s3_err", 32'(Err), 0);

        // Seed all ones, two sweeps: 1 + 32 Up, 32 + 32 Down
        start_run(31, 2);
        wait_idle(300, ups, dns, dones, errd);
        chk("s31_ups", ups, 33);
        chk("s31_dns", dns, 64);
        chk("s31_done", dones, 1);
        chk("s31_sweep", 32'(Sweep_Cnt), 2);

        // Start pulses while busy are ignored
        start_run(5, 1);
        repeat (3) begin
            Seed = 5'd9; Cycles = 4'd3; Start = 1'b1;
            tick();
            Start = 1'b0;
            tick();
        end
        wait_idle(200, ups, dns, dones, errd);
        chk("busy_start_done", dones, 1);
        chk("busy_start_sweep", 32'(Sweep_Cnt), 1);

        // Watchdog: High never asserts, RISE lasts 34 cycles then errors out
        kill_high = 1'b1;
        start_run(0, 1);
        wait_idle(200, ups, dns, dones, errd);
        chk("wd_ups", ups, 34);
        chk("wd_dns", dns, 0);
        chk("wd_done", dones, 1);
        chk("wd_err_at_done", errd, 1);
        tick();
        chk("wd_err_sticky", 32'(Err), 1);
        kill_high = 1'b0;
        start_run(31, 1);
        chk("wd_err_cleared", 32'(Err), 0);
        wait_idle(200, ups, dns, dones, errd);

        // Free-running sweeps wrap the count, then Stop in FALL
        start_run(0, 0);
        wrapped = 1'b0;
        for (int i = 0; i < 1500 && !wrapped; i++) begin
            prev = int'(Sweep_Cnt);
            tick();
            if (prev == 15 && Sweep_Cnt == 4'd0) wrapped = 1'b1;
        end
        chk("free_wrap", 32'(wrapped), 1);
        for (int i = 0; i < 100 && Down !== 1'b1; i++) tick();
        chk("free_in_fall", 32'(Down), 1);
        Stop = 1'b1;
        tick();
        Stop = 1'b0;
        chk("stop_done", 32'(Done), 1);
        chk("stop_busy", 32'(Busy), 1);
        tick();
        chk("stop_idle", 32'(Busy), 0);
        chk("stop_done_gone", 32'(Done), 0);

        // Reset mid-RISE clears everything at once, no Done
        start_run(0, 3);
        repeat (5) tick();
        chk("pre_rst_up", 32'(Up), 1);
        @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("arst_in", 32'(IN), 0);
        chk("arst_drive", {29'd0, Load, Up, Down}, 0);
        chk("arst_status", {29'd0, Busy, Done, Err}, 0);
        chk("arst_sweep", 32'(Sweep_Cnt), 0);
        tick();
        RST = 1'b0;
        repeat (3) begin
            tick();
            chk("arst_no_done", 32'(Done), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
